// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access size and FSM state
// encodings, byte-count conversion and alignment check.
package lsu_pkg;

    localparam int XLEN      = 64;
    localparam int MEM_LEN_W = 32;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    function automatic logic [MEM_LEN_W-1:0] size_to_len(input size_e sz);
        case (sz)
            SZ_B:    return 32'd1;
            SZ_H:    return 32'd2;
            SZ_W:    return 32'd4;
            default: return 32'd8;
        endcase
    endfunction

    // Nonzero address bits below the access size mean the access is misaligned.
    function automatic logic misaligned(input logic [2:0] lo, input size_e sz);
        case (sz)
            SZ_B:    return 1'b0;
            SZ_H:    return (lo[0] != 1'b0);
            SZ_W:    return (lo[1:0] != 2'b00);
            default: return (lo != 3'b000);
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed bytes from a returned doubleword and zero/sign-extends
// them to 64 bits. Bytes past the top of the doubleword read as zero.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] dword,
    input  logic [2:0]  lane,
    input  size_e       size,
    input  logic        is_unsigned,
    output logic [63:0] data
);

    logic [63:0] shifted_s;

    // Lane shift followed by width-dependent extension.
    always_comb begin
        shifted_s = dword >> {lane, 3'b000};
        case (size)
            SZ_B:    data = is_unsigned ? {56'd0, shifted_s[7:0]}
                                        : {{56{shifted_s[7]}}, shifted_s[7:0]};
            SZ_H:    data = is_unsigned ? {48'd0, shifted_s[15:0]}
                                        : {{48{shifted_s[15]}}, shifted_s[15:0]};
            SZ_W:    data = is_unsigned ? {32'd0, shifted_s[31:0]}
                                        : {{32{shifted_s[31]}}, shifted_s[31:0]};
            default: data = shifted_s;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the MEM stage and the memory valid/ready port.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned accesses trap with resp_err).
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int MEM_LEN_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wen,
    input  logic [XLEN-1:0]      req_addr,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [XLEN-1:0]      req_wdata,
    output logic                 resp_valid,
    output logic [XLEN-1:0]      resp_rdata,
    output logic                 resp_err,
    output logic                 mem_en,
    output logic                 mem_wout,
    output logic [XLEN-1:0]      mem_addr,
    output logic [MEM_LEN_W-1:0] mem_len,
    output logic [XLEN-1:0]      mem_wdata,
    output logic                 mem_addr_valid,
    input  logic                 mem_addr_ready,
    output logic                 mem_data_ready,
    input  logic                 mem_data_valid,
    input  logic [XLEN-1:0]      mem_rdata
);

    state_e      state_r;
    logic        wen_r;
    logic [2:0]  lane_r;
    size_e       size_r;
    logic        uns_r;
    logic        trap_r;
    logic        trap_s;
    logic [63:0] ext_s;

    // Alignment trap decision for the incoming request.
    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        trap_s = misaligned(req_addr[2:0], size_e'(req_size));
`else
        trap_s = 1'b0;
`endif
    end

    lsu_load_align u_align (
        .dword       (mem_rdata),
        .lane        (lane_r),
        .size        (size_r),
        .is_unsigned (uns_r),
        .data        (ext_s)
    );

    // Request FSM; every port output is a register updated on state transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            wen_r          <= 1'b0;
            lane_r         <= 3'd0;
            size_r         <= SZ_B;
            uns_r          <= 1'b0;
            trap_r         <= 1'b0;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_rdata     <= 64'd0;
            resp_err       <= 1'b0;
            mem_en         <= 1'b0;
            mem_wout       <= 1'b0;
            mem_addr       <= 64'd0;
            mem_len        <= 32'd0;
            mem_wdata      <= 64'd0;
            mem_addr_valid <= 1'b0;
            mem_data_ready <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        state_r   <= ST_ISSUE;
                        req_ready <= 1'b0;
                        wen_r     <= req_wen;
                        lane_r    <= req_addr[2:0];
                        size_r    <= size_e'(req_size);
                        uns_r     <= req_unsigned;
                        trap_r    <= trap_s;
                        // A trapped access never touches the memory port.
                        if (!trap_s) begin
                            mem_en         <= 1'b1;
                            mem_addr_valid <= 1'b1;
                            mem_wout       <= req_wen;
                            mem_addr       <= req_addr;
                            mem_len        <= size_to_len(size_e'(req_size));
                            mem_wdata      <= req_wdata;
                            mem_data_ready <= req_wen;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (trap_r) begin
                        state_r    <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= 64'd0;
                    end else if (mem_addr_ready) begin
                        mem_en         <= 1'b0;
                        mem_addr_valid <= 1'b0;
                        mem_wout       <= 1'b0;
                        mem_addr       <= 64'd0;
                        mem_len        <= 32'd0;
                        mem_wdata      <= 64'd0;
                        if (wen_r) begin
                            state_r        <= ST_RESP;
                            resp_valid     <= 1'b1;
                            resp_rdata     <= 64'd0;
                            mem_data_ready <= 1'b0;
                        end else begin
                            state_r        <= ST_WAIT_R;
                            mem_data_ready <= 1'b1;
                        end
                    end
                end
                ST_WAIT_R: begin
                    if (mem_data_valid) begin
                        state_r        <= ST_RESP;
                        resp_valid     <= 1'b1;
                        resp_rdata     <= ext_s;
                        mem_data_ready <= 1'b0;
                    end
                end
                ST_RESP: begin
                    state_r    <= ST_IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    trap_r     <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state_r        <= ST_IDLE;
                    req_ready      <= 1'b1;
                    resp_valid     <= 1'b0;
                    resp_err       <= 1'b0;
                    mem_en         <= 1'b0;
                    mem_addr_valid <= 1'b0;
                    mem_data_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
